// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared width, counter size and FSM state type for the Booth unit.
//  Revision : 1.0
// ============================================================================
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
//  Module   : booth_step
//  Purpose  : One radix-2 Booth iteration, i.e. add/sub on {q0,q_1} followed by
//             an arithmetic right shift of {acc,q,q_1}. Purely combinational.
//  Revision : 1.0
// ============================================================================
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = acc;
    case ({q[0], q_1})
      2'b01:   w_sum = acc + m;
      2'b10:   w_sum = acc - m;
      default: w_sum = acc;
    endcase
  end

  // The sign bit is replicated because acc is one bit wider than an operand.
  assign acc_next = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign q_next   = {w_sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule
`default_nettype wire

// File: rtl/booth_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mult_unit
//  Purpose  : Sequential signed WIDTHxWIDTH->2*WIDTH Booth multiplier answering a
//             start/done handshake; result held on HI/LO until the next completion.
//  Revision : 1.0
// ============================================================================
module booth_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             mult_out,
  output logic             busy
);

  localparam int               C_CNT_W = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

  state_t              r_state;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [WIDTH:0]      r_acc;
  logic [WIDTH:0]      r_m;
  logic [WIDTH-1:0]    r_q;
  logic                r_q_1;

  logic [WIDTH:0]      w_acc_next;
  logic [WIDTH-1:0]    w_q_next;
  logic                w_q_1_next;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (r_acc),
    .q        (r_q),
    .q_1      (r_q_1),
    .m        (r_m),
    .acc_next (w_acc_next),
    .q_next   (w_q_next),
    .q_1_next (w_q_1_next)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_q_1    <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      mult_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mult_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mult_in) begin
            r_m     <= {A[WIDTH-1], A};
            r_q     <= B;
            r_acc   <= '0;
            r_q_1   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_q   <= w_q_next;
          r_q_1 <= w_q_1_next;
          r_cnt <= r_cnt + 1'b1;
          // After the final shift the low WIDTH bits of acc are the top product half.
          if (r_cnt == C_LAST) begin
            HI       <= w_acc_next[WIDTH-1:0];
            LO       <= w_q_next;
            mult_out <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_mult_unit
//  Purpose  : Directed-vector and random-sweep self-checking bench for booth_mult_unit.
//  Revision : 1.0
// ============================================================================
module tb_booth_mult_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         mult_in = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         mult_out;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .mult_in  (mult_in),
    .A        (A),
    .B        (B),
    .HI       (HI),
    .LO       (LO),
    .mult_out (mult_out),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start a multiply and return the cycle count to the first done pulse and the product.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [63:0] prod);
    @(negedge clock);
    A = a; B = b; mult_in = 1'b1;
    @(posedge clock); #1;
    mult_in = 1'b0;
    lat = -1;
    prod = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (mult_out) begin
        lat = i;
        prod = {HI, LO};
        break;
      end
    end
  endtask

  vec_t vecs[9];
  int   lat;
  int   pulses;
  int   first;
  logic [63:0] prod;

  initial begin
    vecs[0] = '{32'd3,        32'd5,        64'h0000_0000_0000_000F};
    vecs[1] = '{-32'sd7,      32'd6,        64'hFFFF_FFFF_FFFF_FFD6};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[4] = '{32'd0,        32'hDEAD_BEEF, 64'h0};
    vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
    vecs[7] = '{32'hFFFF_FFFF, 32'd1,        64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8] = '{32'd12345,    -32'sd100,    64'hFFFF_FFFF_FFED_29BC};

    // Reset
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("reset_hi", 64'(HI), 64'h0);
    check("reset_lo", 64'(LO), 64'h0);
    check("reset_done", 64'(mult_out), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);

    // Directed table
    foreach (vecs[k]) begin
      do_mult(vecs[k].a, vecs[k].b, lat, prod);
      check($sformatf("vec%0d_latency", k), 64'(lat), 64'd32);
      check($sformatf("vec%0d_product", k), prod, vecs[k].prod);
      check($sformatf("vec%0d_busy_at_done", k), 64'(busy), 64'h0);
      @(posedge clock); #1;
      check($sformatf("vec%0d_done_one_cycle", k), 64'(mult_out), 64'h0);
      check($sformatf("vec%0d_hold", k), {HI, LO}, vecs[k].prod);
    end

    // Start ignored while busy; operands changed mid-run
    @(negedge clock);
    A = 32'd2; B = 32'd2; mult_in = 1'b1;
    @(posedge clock); #1;
    mult_in = 1'b0;
    check("busy_after_accept", 64'(busy), 64'h1);
    pulses = 0; first = -1;
    for (int i = 1; i <= 70; i++) begin
      if (i == 10) begin A = 32'd9; B = 32'd9; mult_in = 1'b1; end
      if (i == 11) mult_in = 1'b0;
      @(posedge clock); #1;
      if (mult_out) begin
        pulses++;
        if (first < 0) begin first = i; prod = {HI, LO}; end
      end
    end
    check("ignore_pulses", 64'(pulses), 64'd1);
    check("ignore_latency", 64'(first), 64'd32);
    check("ignore_product", prod, 64'd4);

    // Reset mid-run aborts
    @(negedge clock);
    A = 32'd5; B = 32'd5; mult_in = 1'b1;
    @(posedge clock); #1;
    mult_in = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_hilo", {HI, LO}, 64'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (mult_out) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    do_mult(32'd3, 32'd5, lat, prod);
    check("after_abort_latency", 64'(lat), 64'd32);
    check("after_abort_product", prod, 64'h0F);

    // Back-to-back start in the done cycle
    do_mult(32'd3, 32'd7, lat, prod);
    check("b2b_first_product", prod, 64'd21);
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; mult_in = 1'b1;
    @(posedge clock); #1;
    mult_in = 1'b0;
    check("b2b_busy", 64'(busy), 64'h1);
    check("b2b_hold_during_run", {HI, LO}, 64'd21);
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (mult_out) begin first = i; prod = {HI, LO}; break; end
    end
    check("b2b_latency", 64'(first), 64'd32);
    check("b2b_product", prod, 64'd1);

    // Random signed sweep against 64-bit reference
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      longint       ref_p;
      ra = $urandom();
      rb = $urandom();
      if (n % 8 == 0) ra = {ra[W-1], {(W-1){ra[0]}}};
      ref_p = longint'($signed(ra)) * longint'($signed(rb));
      do_mult(ra, rb, lat, prod);
      if (lat != 32 || prod !== 64'(ref_p)) begin
        n_cmp++;
        n_err++;
        $display("FAIL rand%0d a=%h b=%h: got %h (lat %0d) expected %h (lat 32)",
                 n, ra, rb, prod, lat, 64'(ref_p));
      end else begin
        n_cmp++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
